// File: rtl/alu_pkg.sv
// alu_pkg: shared types, constants and CRC-4 reference for the serial ALU decoder.
// No ports. Optional CRC check enabled by ALU_SIN_CRC_CHECK_EN in alu_sin_decoder.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK
  } rx_state_e;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } opcode_e;

  // the 10 bits that follow the start bit
  typedef struct packed {
    logic       typ;
    logic [7:0] payload;
    logic       stop;
  } packet_t;

  // cmd payload layout
  typedef struct packed {
    logic       pad;
    logic [2:0] op;
    logic [3:0] crc;
  } in_crc_t;

  localparam logic       TYPE_DATA = 1'b0;
  localparam logic       TYPE_CMD  = 1'b1;
  localparam int         PKT_BITS  = 10;
  localparam logic [3:0] DATA_FULL = 4'd8;
  localparam logic [3:0] DATA_SAT  = 4'd9;

  // x^4+x+1, init 0, MSB first
  function automatic logic [3:0] crc4(
    input logic [67:0] msg
  );
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0};
      if (fb) c = c ^ 4'b0011;
    end
    return c;
  endfunction

  function automatic logic op_legal(
    input logic [2:0] o
  );
    logic ok;
    ok = 1'b0;
    unique case (o)
      OP_AND, OP_OR,
      OP_ADD, OP_SUB: ok = 1'b1;
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_sin_packet_rx.sv
// alu_sin_packet_rx: frames 11-bit packets off sin (IDLE -> SHIFT -> CHECK).
// Ports: clk, rst_n, sin in; pkt_type, payload, pkt_valid, frame_err out (CHECK cycle).
module alu_sin_packet_rx
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
  output logic       pkt_type,
  output logic [7:0] payload,
  output logic       pkt_valid,
  output logic       frame_err
);

  rx_state_e  state;
  rx_state_e  state_nxt;
  logic [3:0] bit_cnt;
  packet_t    sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      sr      <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_SHIFT) begin
        sr      <= {sr[PKT_BITS-2:0], sin};
        bit_cnt <= bit_cnt + 4'd1;
      end else begin
        bit_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (!sin) state_nxt = ST_SHIFT;
      ST_SHIFT: if (bit_cnt == 4'(PKT_BITS - 1))
                  state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pkt_type  = sr.typ;
    payload   = sr.payload;
    pkt_valid = 1'b0;
    frame_err = 1'b0;
    if (state == ST_CHECK) begin
      pkt_valid = sr.stop;
      frame_err = !sr.stop;
    end
  end

endmodule

// File: rtl/alu_sin_decoder.sv
// alu_sin_decoder: collects 8 data bytes + cmd into a, b, op with error flags.
// Ports: clk, rst_n, sin in; a, b, op, req_valid, err_flags out. Macro: ALU_SIN_CRC_CHECK_EN.
module alu_sin_decoder
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [2:0]  op,
  output logic        req_valid,
  output logic [2:0]  err_flags
);

  logic        pkt_type;
  logic [7:0]  payload;
  logic        pkt_valid;
  logic        frame_err;

  logic [63:0] data_buf;
  logic [3:0]  cnt;
  in_crc_t     cmd;
  logic        is_cmd;
  logic        is_data;
  logic        err_data;
  logic        crc_bad;
  logic        op_bad;
  logic [2:0]  err_nxt;
  logic        unused_bits;

  alu_sin_packet_rx u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .pkt_type  (pkt_type),
    .payload   (payload),
    .pkt_valid (pkt_valid),
    .frame_err (frame_err)
  );

  assign cmd     = in_crc_t'(payload);
  assign is_cmd  = pkt_valid && (pkt_type == TYPE_CMD);
  assign is_data = pkt_valid && (pkt_type == TYPE_DATA);

  assign err_data = (cnt != DATA_FULL);
  assign op_bad   = !op_legal(cmd.op);

`ifdef ALU_SIN_CRC_CHECK_EN
  assign crc_bad     = crc4({data_buf, 1'b1, cmd.op})
                       != cmd.crc;
  assign unused_bits = cmd.pad;
`else
  assign crc_bad     = 1'b0;
  assign unused_bits = ^{cmd.pad, cmd.crc};
`endif

  // data > crc > op; more than one may be true
  always_comb begin
    err_nxt = 3'b000;
    priority case (1'b1)
      err_data: err_nxt = 3'b100;
      crc_bad:  err_nxt = 3'b010;
      op_bad:   err_nxt = 3'b001;
      default:  err_nxt = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_buf  <= '0;
      cnt       <= '0;
      a         <= '0;
      b         <= '0;
      op        <= '0;
      req_valid <= 1'b0;
      err_flags <= '0;
    end else begin
      req_valid <= is_cmd;
      err_flags <= is_cmd ? err_nxt : 3'b000;
      if (is_cmd) begin
        a   <= data_buf[63:32];
        b   <= data_buf[31:0];
        op  <= cmd.op;
        cnt <= '0;
      end else if (is_data) begin
        data_buf <= {data_buf[55:0], payload};
        cnt      <= (cnt == DATA_SAT) ? cnt
                    : cnt + 4'd1;
      end else if (frame_err) begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: doc/alu_sin_decoder.md
ALU_SIN_DECODER -- requirements
Module: alu_sin_decoder

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have sin  input  1  serial ALU request line, idle high, sampled on rising clk.
REQ-004 SHALL have a  output  32  operand A, first data byte = a[31:24].
REQ-005 SHALL have b  output  32  operand B, first data byte = b[31:24].
REQ-006 SHALL have op  output  3  operation code from the command packet.
REQ-007 SHALL have req_valid  output  1  one-cycle pulse marking a complete request.
REQ-008 SHALL have err_flags  output  3  one-hot {err_data, err_crc, err_op}, valid with req_valid.

Function
REQ-009 SHALL decode 11-bit packets, MSB first: start 0, type (0 data, 1 cmd), 8 payload bits, stop 1.
REQ-010 SHALL use FSM IDLE -> SHIFT (10 further bits) -> CHECK -> IDLE; IDLE leaves only on sampled sin=0.
REQ-011 SHALL append data payloads to a 64-bit shift buffer and count them in a 4-bit counter saturating at 9.
REQ-012 SHALL treat cmd payload as {1'b0, op[2:0], crc[3:0]}.
REQ-013 SHALL, on cmd with count!=8, pulse req_valid with err_flags=3'b100.
REQ-014 SHALL, on count==8, compare received CRC against CRC-4 (x^4+x+1, init 0) over {A, B, 1'b1, op}; mismatch -> 3'b010.
REQ-015 SHALL flag valid CRC with op not in {AND 000, OR 001, ADD 100, SUB 101} as 3'b001.
REQ-016 SHALL apply priority data > crc > op; exactly one flag set, or none.
REQ-017 SHALL assert req_valid exactly one cycle after the stop bit of the cmd packet is sampled.
REQ-018 SHALL hold a, b, op stable from req_valid until the next req_valid.
REQ-019 SHALL, on stop bit 0 in any packet, discard the frame, clear counter, return to IDLE, no req_valid.
REQ-020 SHALL clear the data counter after every req_valid.
REQ-021 SHALL accept a new start bit in the cycle immediately following CHECK.

Reset
REQ-022 SHALL on rst_n low: state IDLE, counter 0, buffer 0, a=b=0, op=0, req_valid=0, err_flags=0.
REQ-023 SHALL discard any partial frame when reset asserts mid-packet; first post-reset start bit begins a new frame.

Configuration
REQ-024 SHALL check CRC per REQ-014 when ALU_SIN_CRC_CHECK_EN is defined.
REQ-025 SHALL, without ALU_SIN_CRC_CHECK_EN, never set err_crc and omit the CRC logic.

Structure
REQ-026 SHALL take packet_t, opcode enum, in_crc_t and the CRC-4 reference function from alu_pkg.
REQ-027 SHALL place packet shift/framing in sub-module alu_sin_packet_rx (outputs type, payload, pkt_valid, frame_err).

Verification
REQ-028 A=32'h00000001, B=32'h00000002, op=ADD, correct CRC -> req_valid once, a/b/op match, err_flags=000.
REQ-029 Same request with CRC XOR 4'h1 -> err_flags=010 (000 if macro undefined).
REQ-030 7 data packets then cmd -> err_flags=100; 9 data packets then cmd -> err_flags=100.
REQ-031 Correct CRC, op=3'b111 -> err_flags=001.
REQ-032 Stop bit forced 0 in packet 3, then full valid request -> exactly one req_valid, err_flags=000.
REQ-033 rst_n low during packet 5, then valid request A=B=32'hffffffff, op=AND -> correct outputs, err_flags=000.
